apb_master: RTL
===============

Name: apb_master

Overview:
- APB requester: the initiator end of the bus that apb_top answers as completer.
- Accepts single read/write commands over a valid/ready command port.
- Sequences the APB SETUP and ACCESS phases, waits for PREADY, then returns read data and the error flag over a valid/ready response port.
- Sits between test/firmware-side traffic generators and any APB completer.

Parameters:
- addr_width, 4, width of PADDR and cmd_addr
- data_width, 128, width of PWDATA/PRDATA and command/response data
- timeout_cycles, 16, max ACCESS wait cycles before abort (used only with the optional feature)

Ports:
- PCLK  input  1  single clock; all logic on rising edge
- PRESET  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  addr_width  transfer address
- cmd_wdata  input  data_width  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_rdata  output  data_width  read data (0 for writes)
- rsp_error  output  1  PSLVERR captured, or timeout abort
- PSELx  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  addr_width  APB address
- PWDATA  output  data_width  APB write data
- PRDATA  input  data_width  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB error

Behaviour:
- Reset (PRESET=1 at an edge): state IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_error = 0; PADDR, PWDATA, rsp_rdata = 0; cmd_ready=0 during reset, 1 from first cycle after.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. When cmd_valid&&cmd_ready, register write/addr/wdata and go to SETUP. cmd_ready=0 in every other state.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0; PADDR/PWRITE/PWDATA from registered command. Go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable. PREADY=0 holds in ACCESS indefinitely.
- ACCESS with PREADY=1:
  - Capture PSLVERR into rsp_error.
  - For reads, capture PRDATA into rsp_rdata; for writes, rsp_rdata=0.
  - Next cycle: PSELx=0, PENABLE=0, state RESP.
- PRDATA and PSLVERR are ignored outside the ACCESS&&PREADY cycle.
- RESP: rsp_valid=1; rsp_rdata/rsp_error stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE; rsp_valid=0 next cycle.
- Zero-wait latency: accept at cycle T; SETUP T+1; ACCESS T+2; rsp_valid T+3. Minimum 4 cycles per transfer (with rsp_ready tied high).
- Only one transfer outstanding; no pipelining.
- PWDATA driven with the registered value on reads as well (don't-care per APB; no X).
- Reset mid-transfer (any state): abandon at that edge, all outputs to reset values, no response emitted.
- PSELx never rises without a SETUP cycle first; PENABLE never high while PSELx low.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches timeout_cycles with PREADY still 0: drop PSELx/PENABLE, rsp_error=1, rsp_rdata=0, go to RESP.
  - PREADY=1 in the same cycle the limit is reached wins: normal completion.
- Not defined: no counter logic; ACCESS waits forever; timeout_cycles unused.

Decomposition:
- Package apb_pkg:
  - apb_state_e enum (IDLE, SETUP, ACCESS, RESP)
  - apb_cmd_t struct (write, addr, wdata), parameterised via package constants APB_ADDR_W=4, APB_DATA_W=128 as defaults
- Sub-module apb_wait_timer: counter with clear/enable/limit-hit, instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr=4'h3, wdata=128'hDEAD_BEEF, PREADY tied 1 -> PSELx high T+1..T+2, PENABLE high T+2 only, PWRITE=1, PADDR=3; rsp_valid at T+3, rsp_error=0, rsp_rdata=0.
- Read addr=4'hA, completer inserts 3 wait states, PRDATA=128'h1234 on the ready cycle -> PADDR stable through all ACCESS cycles; rsp_rdata=128'h1234 at T+6.
- Read with PSLVERR=1 on the ready cycle -> rsp_error=1. Next command with PSLVERR=0 -> rsp_error=0 (no sticky).
- rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout; a new command is accepted only the cycle after rsp_ready=1.
- PRESET asserted during ACCESS -> next cycle PSELx=0, PENABLE=0, rsp_valid=0, state IDLE; cmd_ready=1 the cycle after PRESET deasserts.
- With APB_MASTER_TIMEOUT_EN, timeout_cycles=4, PREADY never high -> abort after 4 ACCESS cycles, rsp_error=1, rsp_rdata=0. Without the macro, the same stimulus keeps PENABLE high forever.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the captured command record.
package apb_pkg;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals seen by the requester (master) and its peer (slave).
interface apb_master_if #(
    parameter int addr_width = apb_pkg::APB_ADDR_W,
    parameter int data_width = apb_pkg::APB_DATA_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [addr_width-1:0] cmd_addr;
    logic [data_width-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [data_width-1:0] rsp_rdata;
    logic                  rsp_error;

    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [addr_width-1:0] PADDR;
    logic [data_width-1:0] PWDATA;
    logic [data_width-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait counter for the APB_MASTER_TIMEOUT_EN build: flags the cycle in which the limit is reached.
module apb_wait_timer #(
    parameter int limit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);
    localparam int CNT_W = (limit > 1) ? $clog2(limit) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // the limit-th stalled cycle is the one that observes count == limit-1
    assign limit_hit = enable && (count == CNT_W'(limit - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, result returned on a valid/ready port.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after timeout_cycles stalled cycles.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSELx high, PENABLE low, one cycle
// ACCESS | PSELx and PENABLE high, waiting for PREADY
// RESP   | rsp_valid high until rsp_ready
module apb_master
    import apb_pkg::*;
#(
    parameter int addr_width     = APB_ADDR_W,
    parameter int data_width     = APB_DATA_W,
    parameter int timeout_cycles = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    apb_state_e            state;
    logic                  cmd_ready;
    logic                  rsp_valid;
    logic                  rsp_error;
    logic [data_width-1:0] rsp_rdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [addr_width-1:0] paddr;
    logic [data_width-1:0] pwdata;
    logic                  accept;

    assign accept = bus.cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic wait_clear;
    logic wait_count;
    logic timeout_hit;

    assign wait_clear = (state == SETUP);
    assign wait_count = (state == ACCESS) && !bus.PREADY;

    apb_wait_timer #(.limit(timeout_cycles)) u_wait_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .clear     (wait_clear),
        .enable    (wait_count),
        .limit_hit (timeout_hit)
    );
`else
    if (timeout_cycles < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pwrite    <= bus.cmd_write;
                        paddr     <= bus.cmd_addr;
                        pwdata    <= bus.cmd_wdata;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout hit in the same cycle
                    if (bus.PREADY) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= bus.PSLVERR;
                        rsp_rdata <= pwrite ? '0 : bus.PRDATA;
                        state     <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_error = rsp_error;
    assign bus.PSELx     = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PADDR     = paddr;
    assign bus.PWDATA    = pwdata;

endmodule
